// File: rtl/stream_pkg.sv
// stream_pkg: state encoding and default geometry shared by the delayed pixel stream stages
package stream_pkg;

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_DATA_W   = 10;

endpackage

// File: rtl/xy_counter.sv
// xy_counter: enable-driven column/row counter with exact wrap; clr restarts at 0,0 and an enabled beat in the same cycle counts as beat 0
module xy_counter #(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int H_MAX = 640,
    parameter int V_MAX = 480
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           clr,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           x_wrap,
    output logic           xy_last
);

    logic [X_W-1:0] x_b, x_n;
    logic [Y_W-1:0] y_b, y_n;
    logic           wrap_b;

    assign x_wrap  = x == X_W'(H_MAX - 1);
    assign xy_last = x_wrap && y == Y_W'(V_MAX - 1);

    // next count from the (possibly cleared) base value
    always_comb begin
        x_b    = clr ? '0 : x;
        y_b    = clr ? '0 : y;
        wrap_b = x_b == X_W'(H_MAX - 1);
        x_n    = !en ? x_b : wrap_b ? '0 : x_b + 1'b1;
        y_n    = !(en && wrap_b) ? y_b : (y_b == Y_W'(V_MAX - 1)) ? '0 : y_b + 1'b1;
    end

    // counter registers
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_n;
            y <= y_n;
        end
    end

endmodule

// File: rtl/delay_stream_rx.sv
// delay_stream_rx: drops line-buffer warm-up lines and emits a coordinate-tagged stream; DELAY_RX_STAT_EN adds the obj_cnt threshold counter
module delay_stream_rx
    import stream_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int LINE_SKIP = 2,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
`ifdef DELAY_RX_STAT_EN
    , parameter logic [DATA_W-1:0] THRESH = 10'd512
`endif
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              frame_start,
    input  logic              ien,
    input  logic [DATA_W-1:0] din,
    output logic              oen,
    output logic [DATA_W-1:0] dout,
    output logic [X_W-1:0]    x_pos,
    output logic [Y_W-1:0]    y_pos,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              frame_err,
    output logic              busy
`ifdef DELAY_RX_STAT_EN
    , output logic [X_W+Y_W-1:0] obj_cnt
`endif
);

    state_t         state, state_n, restart_st;
    logic [X_W-1:0] x, ox;
    logic [Y_W-1:0] y, oy;
    logic           x_wrap, xy_last, cnt_clr, cnt_en;
    logic           eof_beat, start, skip_end, out_beat, is_sof, ferr;

    assign restart_st = (LINE_SKIP == 0) ? ACTIVE : SKIP;

    // one counter serves as skip-line counter in SKIP and as pixel coordinates in ACTIVE
    xy_counter #(
        .X_W  (X_W),
        .Y_W  (Y_W),
        .H_MAX(H_ACTIVE),
        .V_MAX(V_ACTIVE)
    ) u_cnt (
        .clk    (clk),
        .aclr   (aclr),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .x      (x),
        .y      (y),
        .x_wrap (x_wrap),
        .xy_last(xy_last)
    );

    // next state, counter control and the beat about to be registered; an eof beat wins over a coincident frame_start
    always_comb begin
        eof_beat = state == ACTIVE && ien && xy_last;
        start    = frame_start && !eof_beat;
        skip_end = state == SKIP && ien && x_wrap && y == Y_W'(LINE_SKIP - 1);
        out_beat = start ? (LINE_SKIP == 0) && ien : state == ACTIVE && ien;
        ox       = start ? '0 : x;
        oy       = start ? '0 : y;
        is_sof   = out_beat && ox == '0 && oy == '0;
        ferr     = start && state != IDLE;
        cnt_clr  = frame_start || eof_beat || skip_end;
        cnt_en   = start ? ien : state != IDLE && ien && !eof_beat && !skip_end;
        state_n  = frame_start ? restart_st : eof_beat ? IDLE : skip_end ? ACTIVE : state;
    end

    // state register and registered output stream
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            oen       <= 1'b0;
            dout      <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            oen       <= out_beat;
            if (out_beat) begin
                dout  <= din;
                x_pos <= ox;
                y_pos <= oy;
            end
            sof       <= is_sof;
            eol       <= out_beat && ox == X_W'(H_ACTIVE - 1);
            eof       <= out_beat && ox == X_W'(H_ACTIVE - 1) && oy == Y_W'(V_ACTIVE - 1);
            frame_err <= ferr;
            busy      <= state_n != IDLE;
        end
    end

`ifdef DELAY_RX_STAT_EN
    localparam int CW = X_W + Y_W;
    logic [CW-1:0] acc;

    // count over-threshold output beats from sof; publish the total the cycle after eof
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc     <= '0;
            obj_cnt <= '0;
        end else begin
            if (out_beat)
                acc <= (is_sof ? '0 : acc) + CW'(din >= THRESH);
            if (eof)
                obj_cnt <= acc;
        end
    end
`endif

endmodule

// File: tb/tb_delay_stream_rx.sv
// tb_delay_stream_rx: directed checks of delay_stream_rx on a reduced 8x4 geometry with two warm-up lines
module tb_delay_stream_rx;

    localparam int DW = 10;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LS = 2;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int NS = H * LS;

    logic          clk = 1'b0;
    logic          aclr, frame_start, ien;
    logic [DW-1:0] din, dout;
    logic          oen, sof, eol, eof, frame_err, busy;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
`ifdef DELAY_RX_STAT_EN
    logic [XW+YW-1:0] obj_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int eols, oens;

    delay_stream_rx #(
        .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .LINE_SKIP(LS), .X_W(XW), .Y_W(YW)
    ) dut (
        .clk(clk), .aclr(aclr), .frame_start(frame_start), .ien(ien), .din(din),
        .oen(oen), .dout(dout), .x_pos(x_pos), .y_pos(y_pos), .sof(sof), .eol(eol),
        .eof(eof), .frame_err(frame_err), .busy(busy)
`ifdef DELAY_RX_STAT_EN
        , .obj_cnt(obj_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic f, input logic e, input int d);
        frame_start = f;
        ien         = e;
        din         = DW'(d);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ien         = 1'b0;
    endtask

    task automatic chk_act(input int a, input int d);
        chk("oen", 32'(oen), 1);
        chk("dout", 32'(dout), d);
        chk("x_pos", 32'(x_pos), a % H);
        chk("y_pos", 32'(y_pos), a / H);
        chk("sof", 32'(sof), 32'(a == 0));
        chk("eol", 32'(eol), 32'(a % H == H - 1));
        chk("eof", 32'(eof), 32'(a == H * V - 1));
    endtask

    task automatic skip_beats(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 600);
            chk("skip_oen", 32'(oen), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr = 1'b1; frame_start = 1'b0; ien = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oen", 32'(oen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_err", 32'(frame_err), 0);
        aclr = 1'b0;
        // beats without a frame_start are ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5);
            chk("idle_oen", 32'(oen), 0);
            chk("idle_busy", 32'(busy), 0);
        end
        // contiguous frame: 16 skipped beats then 32 tagged beats
        step(1'b1, 1'b0, 0);
        chk("fs_busy", 32'(busy), 1);
        chk("fs_err", 32'(frame_err), 0);
        eols = 0;
        for (int k = 0; k < NS + H * V; k++) begin
            step(1'b0, 1'b1, k);
            if (k < NS) chk("skip_oen", 32'(oen), 0);
            else chk_act(k - NS, k);
            if (eol) eols++;
        end
        chk("eol_count", 32'(eols), V);
        chk("busy_after_eof", 32'(busy), 0);
        step(1'b0, 1'b0, 0);
        chk("idle_after_oen", 32'(oen), 0);
        // bubbles on every other cycle
        step(1'b1, 1'b0, 0);
        oens = 0;
        for (int k = 0; k < NS + H * V; k++) begin
            step(1'b0, 1'b1, k);
            if (oen) oens++;
            if (k >= NS) chk_act(k - NS, k);
            step(1'b0, 1'b0, 0);
            if (oen) oens++;
            chk("bubble_oen", 32'(oen), 0);
        end
        chk("bubble_total", 32'(oens), H * V);
        // truncation: frame_start after 10 active beats
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < NS + 10; k++) step(1'b0, 1'b1, k);
        chk("trunc_pre_oen", 32'(oen), 1);
        step(1'b1, 1'b0, 0);
        chk("trunc_err", 32'(frame_err), 1);
        chk("trunc_oen", 32'(oen), 0);
        chk("trunc_busy", 32'(busy), 1);
        step(1'b0, 1'b0, 0);
        chk("trunc_err_pulse", 32'(frame_err), 0);
        skip_beats(NS);
        step(1'b0, 1'b1, 77);
        chk_act(0, 77);
        // frame_start with ien mid-frame: that beat is skip beat 0 of the new frame
        for (int a = 1; a < 20; a++) step(1'b0, 1'b1, a);
        step(1'b1, 1'b1, 99);
        chk("fsien_err", 32'(frame_err), 1);
        chk("fsien_oen", 32'(oen), 0);
        skip_beats(NS - 1);
        step(1'b0, 1'b1, 55);
        chk_act(0, 55);
        // frame_start on the eof beat: eof is delivered, no error, new frame starts afterwards
        for (int a = 1; a < H * V - 1; a++) begin
            step(1'b0, 1'b1, a);
            chk_act(a, a);
        end
        step(1'b1, 1'b1, 300);
        chk_act(H * V - 1, 300);
        chk("eoffs_err", 32'(frame_err), 0);
        chk("eoffs_busy", 32'(busy), 1);
        skip_beats(NS);
        // this frame also exercises the threshold counter: 10 beats of 600, skip beats excluded
        step(1'b0, 1'b1, 88);
        chk_act(0, 88);
        for (int a = 1; a < H * V; a++) begin
            step(1'b0, 1'b1, (a >= 5 && a < 15) ? 600 : 0);
            chk_act(a, (a >= 5 && a < 15) ? 600 : 0);
        end
        step(1'b0, 1'b0, 0);
`ifdef DELAY_RX_STAT_EN
        chk("obj_cnt", 32'(obj_cnt), 10);
`endif
        chk("post_busy", 32'(busy), 0);
        // asynchronous reset while an output beat is showing
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < NS + 4; k++) step(1'b0, 1'b1, k);
        chk("pre_rst_oen", 32'(oen), 1);
        #2 aclr = 1'b1;
        #1;
        chk("arst_oen", 32'(oen), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_x", 32'(x_pos), 0);
        chk("arst_eol", 32'(eol), 0);
`ifdef DELAY_RX_STAT_EN
        chk("arst_obj", 32'(obj_cnt), 0);
`endif
        #3 aclr = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 9);
            chk("post_rst_oen", 32'(oen), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        step(1'b1, 1'b0, 0);
        skip_beats(NS);
        step(1'b0, 1'b1, 3);
        chk_act(0, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
